mcb_cmd_arb: RTL and testbench
==============================

MCB_CMD_ARB -- requirements
Module: mcb_cmd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, width of host/command address.
REQ-002 SHALL have parameter STARVE_MAX, default 8, max consecutive host grants while refresh pending.
REQ-003 SHALL have parameter ACK_TO, default 4, cycles allowed for sequencer to drop c_ready after issue.
REQ-004 mcb_clk  in  1  sole clock, all state on rising edge.
REQ-005 mcb_rst_n  in  1  synchronous active-low reset.
REQ-006 i_ready  in  1  SDRAM init complete; no grants while 0.
REQ-007 r_ref_req  in  1  refresh controller requests a refresh.
REQ-008 r_ref_alert  in  1  refresh urgent (postponement limit reached).
REQ-009 h_req  in  1  host command valid; held until h_ack.
REQ-010 h_we  in  1  host write (1) / read (0); stable while h_req.
REQ-011 h_addr  in  ADDR_W  host address; stable while h_req.
REQ-012 h_ack  out  1  one-cycle host accept pulse.
REQ-013 c_ready  in  1  command sequencer idle.
REQ-014 c_ref  out  1  one-cycle refresh issue pulse (to sequencer and refresh controller).
REQ-015 c_cmd_vld  out  1  one-cycle host command issue pulse.
REQ-016 c_cmd_we  out  1  latched h_we, valid with c_cmd_vld.
REQ-017 c_cmd_addr  out  ADDR_W  latched h_addr, valid with c_cmd_vld.
REQ-018 a_busy  out  1  1 whenever state is not IDLE.
REQ-019 a_err  out  1  sticky: sequencer failed to drop c_ready within ACK_TO.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_LO, WAIT_HI; all outputs registered.
REQ-021 IDLE, edge with i_ready=1, c_ready=1: refresh wins if r_ref_req=1 and (r_ref_alert=1 or h_req=0 or starve_cnt==STARVE_MAX).
REQ-022 Refresh win at edge k: c_ref=1 for exactly cycle k+1; go WAIT_LO; starve_cnt cleared to 0.
REQ-023 Else if h_req=1 at edge k: h_ack=1, c_cmd_vld=1, c_cmd_we/c_cmd_addr loaded from h_we/h_addr, all for cycle k+1; go WAIT_LO.
REQ-024 Host grant with r_ref_req=1: starve_cnt increments, saturates at STARVE_MAX; host grant with r_ref_req=0: starve_cnt cleared.
REQ-025 starve_cnt width SHALL be clog2(STARVE_MAX+1); no wrap.
REQ-026 IDLE with i_ready=0 or c_ready=0: no issue, remain IDLE, starve_cnt held.
REQ-027 WAIT_LO: c_ready=0 sampled -> WAIT_HI; timer counts cycles in WAIT_LO; timer reaching ACK_TO -> a_err=1, go IDLE.
REQ-028 WAIT_HI: c_ready=1 sampled -> IDLE; no timeout in WAIT_HI.
REQ-029 At most one issue pulse (c_ref or c_cmd_vld) per IDLE visit; c_ref and c_cmd_vld SHALL never be 1 together.
REQ-030 Back-to-back: minimum spacing between issue pulses is 3 cycles (issue, WAIT_LO, WAIT_HI exit).
REQ-031 c_cmd_we/c_cmd_addr SHALL hold last granted value until next host grant.
REQ-032 i_ready falling mid-transaction SHALL not abort WAIT_LO/WAIT_HI; only blocks next grant.
REQ-033 r_ref_alert without r_ref_req SHALL be ignored.

Reset
REQ-034 mcb_rst_n=0 at an edge SHALL force IDLE, starve_cnt=0, timer=0, a_err=0, h_ack=c_ref=c_cmd_vld=c_cmd_we=0, c_cmd_addr=0, a_busy=0 the following cycle.
REQ-035 Reset mid-WAIT_LO/WAIT_HI SHALL abandon transaction; no pulse re-issued after reset.
REQ-036 First grant possible at first edge with mcb_rst_n=1 and IDLE conditions met.

Verification
REQ-037 Host only: h_req=1, h_we=1, h_addr=0x00ABCD, c_ready drops cycle after issue, rises 3 cycles later -> one h_ack/c_cmd_vld pulse, c_cmd_addr=0x00ABCD, c_cmd_we=1, a_busy 1 until c_ready rises.
REQ-038 Simultaneous h_req=1, r_ref_req=1, r_ref_alert=1 -> c_ref first; h_ack only in the following IDLE grant.
REQ-039 Starvation: h_req held continuously, r_ref_req=1, r_ref_alert=0, STARVE_MAX=8 -> exactly 8 host grants then c_ref, starve_cnt back to 0.
REQ-040 Timeout: c_ready held 1 after c_ref -> after ACK_TO=4 cycles in WAIT_LO a_err=1, FSM IDLE, a_err stays 1 until reset.
REQ-041 i_ready=0 with h_req=1, r_ref_req=1 -> no pulses; i_ready=1 -> refresh issued next cycle.
REQ-042 mcb_rst_n=0 during WAIT_HI -> next cycle all outputs 0, IDLE; no spurious pulse after release.

Source files
------------

// File: rtl/mcb_cmd_arb_if.sv
// Command-arbiter bus: init/refresh/host requests in, sequencer issue and status out.
interface mcb_cmd_arb_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              i_ready;
  logic              r_ref_req;
  logic              r_ref_alert;
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic              h_ack;
  logic              c_ready;
  logic              c_ref;
  logic              c_cmd_vld;
  logic              c_cmd_we;
  logic [ADDR_W-1:0] c_cmd_addr;
  logic              a_busy;
  logic              a_err;

  modport master (
    output i_ready, r_ref_req, r_ref_alert, h_req, h_we, h_addr, c_ready,
    input  h_ack, c_ref, c_cmd_vld, c_cmd_we, c_cmd_addr, a_busy, a_err
  );

  modport slave (
    input  i_ready, r_ref_req, r_ref_alert, h_req, h_we, h_addr, c_ready,
    output h_ack, c_ref, c_cmd_vld, c_cmd_we, c_cmd_addr, a_busy, a_err
  );
endinterface

// File: rtl/mcb_cmd_arb.sv
// Refresh/host command arbiter for the memory sequencer, with starvation
// guard for pending refreshes and a timeout on the sequencer handshake.
module mcb_cmd_arb #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned ACK_TO     = 4
) (
  input logic          mcb_clk,
  input logic          mcb_rst_n,
  mcb_cmd_arb_if.slave bus
);
  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned TM_W = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic [TM_W-1:0]   timer, timer_nxt;
  logic              ref_win, host_win, err_nxt;

  logic              h_ack_q, c_ref_q, c_cmd_vld_q, c_cmd_we_q, a_busy_q, a_err_q;
  logic [ADDR_W-1:0] c_cmd_addr_q;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    timer_nxt  = timer;
    ref_win    = 1'b0;
    host_win   = 1'b0;
    err_nxt    = a_err_q;
    unique case (state)
      IDLE: begin
        timer_nxt = '0;
        if (bus.i_ready && bus.c_ready) begin
          if (bus.r_ref_req && (bus.r_ref_alert || !bus.h_req ||
                                starve_cnt == SC_W'(STARVE_MAX))) begin
            ref_win    = 1'b1;
            starve_nxt = '0;
            state_nxt  = WAIT_LO;
          end else if (bus.h_req) begin
            host_win  = 1'b1;
            state_nxt = WAIT_LO;
            // Count only grants that overtook a waiting refresh; saturate.
            if (!bus.r_ref_req)
              starve_nxt = '0;
            else if (starve_cnt != SC_W'(STARVE_MAX))
              starve_nxt = starve_cnt + SC_W'(1);
          end
        end
      end
      WAIT_LO: begin
        if (!bus.c_ready) begin
          state_nxt = WAIT_HI;
          timer_nxt = '0;
        end else if (timer == TM_W'(ACK_TO - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TM_W'(1);
        end
      end
      WAIT_HI: begin
        if (bus.c_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      timer        <= '0;
      h_ack_q      <= 1'b0;
      c_ref_q      <= 1'b0;
      c_cmd_vld_q  <= 1'b0;
      c_cmd_we_q   <= 1'b0;
      c_cmd_addr_q <= '0;
      a_busy_q     <= 1'b0;
      a_err_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      timer       <= timer_nxt;
      h_ack_q     <= host_win;
      c_cmd_vld_q <= host_win;
      c_ref_q     <= ref_win;
      if (host_win) begin
        c_cmd_we_q   <= bus.h_we;
        c_cmd_addr_q <= bus.h_addr;
      end
      a_busy_q <= (state_nxt != IDLE);
      a_err_q  <= err_nxt;
    end
  end

  assign bus.h_ack      = h_ack_q;
  assign bus.c_ref      = c_ref_q;
  assign bus.c_cmd_vld  = c_cmd_vld_q;
  assign bus.c_cmd_we   = c_cmd_we_q;
  assign bus.c_cmd_addr = c_cmd_addr_q;
  assign bus.a_busy     = a_busy_q;
  assign bus.a_err      = a_err_q;
endmodule

// File: tb/tb_mcb_cmd_arb.sv
// Bench for mcb_cmd_arb: transaction-level model predicts issue pulses into a
// scoreboard queue; a monitor pops and compares on every falling edge.
module tb_mcb_cmd_arb;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned ACK_TO     = 4;

  logic mcb_clk   = 1'b0;
  logic mcb_rst_n = 1'b0;

  mcb_cmd_arb_if #(.ADDR_W(ADDR_W)) bus ();

  mcb_cmd_arb #(
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(STARVE_MAX),
    .ACK_TO    (ACK_TO)
  ) dut (
    .mcb_clk  (mcb_clk),
    .mcb_rst_n(mcb_rst_n),
    .bus      (bus)
  );

  always #5 mcb_clk = ~mcb_clk;

  int cyc = 0;
  always @(posedge mcb_clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    bit                is_ref;
    bit                we;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic              hold_we   = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;

  // Requester / sequencer knobs and model state
  bit                h_pend = 0, h_we_v = 0, h_always = 0;
  logic [ADDR_W-1:0] h_addr_v = '0;
  bit                ref_pend = 0, alert_v = 0, irdy_v = 1, crdy_idle = 1;
  bit                plan_to = 0;
  int                plan_d = 0, plan_L = 3;
  int                t_edge = -100, free_edge = 0, t_d = 0, t_L = 1;
  bit                t_to = 0;
  int                starve_m = 0;
  bit                err_set = 0;
  int                err_edge = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: pulses must appear exactly in the predicted cycle
  initial begin
    exp_t e;
    int   c;
    forever begin
      @(negedge mcb_clk);
      c = cyc;
      chk("dual_issue", 64'(bus.c_ref & bus.c_cmd_vld), 64'(0));
      while (q.size() > 0 && q[0].cyc < c) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse cycle %0d: got none, expected pulse in cycle %0d", c, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == c) begin
        e = q.pop_front();
        chk("c_ref",     64'(bus.c_ref),     64'(e.is_ref));
        chk("c_cmd_vld", 64'(bus.c_cmd_vld), 64'(!e.is_ref));
        chk("h_ack",     64'(bus.h_ack),     64'(!e.is_ref));
        if (!e.is_ref) begin
          hold_we   = e.we;
          hold_addr = e.addr;
        end
      end else begin
        chk("idle_pulses", 64'({bus.h_ack, bus.c_ref, bus.c_cmd_vld}), 64'(0));
      end
      chk("c_cmd_we",   64'(bus.c_cmd_we),   64'(hold_we));
      chk("c_cmd_addr", 64'(bus.c_cmd_addr), 64'(hold_addr));
    end
  end

  task automatic step();
    int   c, e;
    bit   crdy, take_ref;
    logic [31:0] r;
    @(negedge mcb_clk);
    c = cyc;
    e = c + 1;
    chk("a_busy", 64'(bus.a_busy), 64'(c >= t_edge && c <= free_edge - 2));
    chk("a_err",  64'(bus.a_err),  64'(err_set && c >= err_edge));
    if (h_always && !h_pend) begin
      r = $urandom;
      h_pend   = 1;
      h_we_v   = r[0];
      h_addr_v = r[ADDR_W:1];
    end
    crdy = crdy_idle;
    if (e > t_edge && e < free_edge)
      crdy = !(!t_to && e >= t_edge + 1 + t_d && e <= t_edge + t_d + t_L);
    mcb_rst_n       = 1'b1;
    bus.i_ready     = irdy_v;
    bus.r_ref_req   = ref_pend;
    bus.r_ref_alert = alert_v;
    bus.h_req       = h_pend;
    bus.h_we        = h_we_v;
    bus.h_addr      = h_addr_v;
    bus.c_ready     = crdy;
    if (e >= free_edge && irdy_v && crdy && (ref_pend || h_pend)) begin
      take_ref = ref_pend && (alert_v || !h_pend || starve_m == int'(STARVE_MAX));
      q.push_back('{cyc: e, is_ref: take_ref, we: h_we_v, addr: h_addr_v});
      if (take_ref) begin
        starve_m = 0;
        ref_pend = 0;
      end else begin
        if (!ref_pend) starve_m = 0;
        else if (starve_m < int'(STARVE_MAX)) starve_m++;
        h_pend = 0;
      end
      t_edge = e;
      t_to   = plan_to;
      t_d    = plan_d;
      t_L    = plan_L;
      if (plan_to) begin
        free_edge = e + int'(ACK_TO) + 1;
        if (!err_set) begin
          err_set  = 1;
          err_edge = e + int'(ACK_TO);
        end
      end else begin
        free_edge = e + 2 + plan_d + plan_L;
      end
    end
  endtask

  task automatic do_reset(int n);
    @(negedge mcb_clk);
    mcb_rst_n = 1'b0;
    t_edge    = -100;
    free_edge = cyc + 1 + n;
    err_set   = 0;
    starve_m  = 0;
    @(posedge mcb_clk);
    #1;
    hold_we   = 1'b0;
    hold_addr = '0;
    repeat (n - 1) @(posedge mcb_clk);
  endtask

  initial begin
    logic [31:0] r;
    bus.i_ready = 0; bus.r_ref_req = 0; bus.r_ref_alert = 0; bus.h_req = 0;
    bus.h_we = 0; bus.h_addr = '0; bus.c_ready = 1;
    do_reset(2);

    // host-only write, sequencer low for 3 cycles
    h_pend = 1; h_we_v = 1; h_addr_v = 24'h00ABCD; plan_d = 0; plan_L = 3;
    repeat (8) step();

    // urgent refresh beats a simultaneous host request
    h_pend = 1; h_we_v = 0; h_addr_v = 24'h123456; ref_pend = 1; alert_v = 1; plan_L = 1;
    repeat (10) step();
    alert_v = 0;

    // starvation guard: continuous host traffic, non-urgent refresh
    h_always = 1; ref_pend = 1;
    repeat (9 * 3 + 6) step();
    h_always = 0;
    repeat (6) step();

    // sequencer never drops c_ready after a refresh
    ref_pend = 1; plan_to = 1;
    repeat (ACK_TO + 4) step();
    plan_to = 0;

    // init not complete blocks grants, then urgent refresh wins
    irdy_v = 0; h_pend = 1; h_we_v = 1; h_addr_v = 24'hFEDCBA; ref_pend = 1; alert_v = 1;
    repeat (5) step();
    irdy_v = 1;
    repeat (10) step();
    alert_v = 0;

    // reset while waiting for the sequencer to come back
    h_pend = 1; h_we_v = 0; h_addr_v = 24'h0F0F0F; plan_L = 5;
    repeat (3) step();
    do_reset(1);
    plan_L = 1;
    repeat (6) step();

    // randomized traffic
    repeat (3000) begin
      r = $urandom;
      if (!h_pend && r[1:0] == 2'd0) begin
        h_pend   = 1;
        h_we_v   = r[2];
        h_addr_v = 24'($urandom);
      end
      if (!ref_pend && r[5:3] == 3'd0) ref_pend = 1;
      alert_v   = (r[7:6] == 2'd0);
      irdy_v    = ($urandom_range(0, 9) != 0);
      crdy_idle = ($urandom_range(0, 7) != 0);
      plan_to   = ($urandom_range(0, 9) == 0);
      plan_d    = int'($urandom_range(0, ACK_TO - 1));
      plan_L    = int'($urandom_range(1, 4));
      if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
      step();
    end

    h_pend = 0; ref_pend = 0; h_always = 0; alert_v = 0; irdy_v = 1; crdy_idle = 1; plan_to = 0;
    repeat (12) step();
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
